alu_pipe: RTL and testbench

- Parametrised successor to the single-cycle execute ALU.
- XLEN-wide integer/branch unit with a valid/ready issue handshake, ROB tag passthrough and an in-order result FIFO toward the CDB arbiter.
- Supports flush on misprediction and a global pause via rdy_in.
- Sits between the RS issue port and the CDB.

---
 rtl/alu_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Purpose : XLEN-wide integer/branch execute unit with ROB-tag passthrough and an in-order result FIFO toward the CDB.
// Latency : 1 cycle for ALU/branch ops (out_valid the cycle after accept); MUL_STAGES cycles for MUL ops when enabled.
// Backpr. : credit-based; in_ready = rdy_in & !flush_in & (count + inflight < FIFO_DEPTH), independent of out_ready.
//
// Optional feature macro: ALU_PIPE_MUL_EN (MUL/MULH/MULHSU/MULHU through a MUL_STAGES-deep pipe; MUL_STAGES >= 2).
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global pause), flush_in (sync discard)
//   in_valid/in_ready issue handshake; in_op, in_vi, in_vj, in_imm, in_pc, in_full_len, in_tag
//   out_valid/out_ready result handshake; out_res, out_taken, out_tag from the FIFO head
//
// Opcode encoding (in_op, 0 = no-op):
//   1 LUI   2 ADD   3 SUB   4 AND   5 OR    6 XOR   7 SLL   8 SRL   9 SRA  10 SLT  11 SLTU
//  12 ADDI 13 ANDI 14 ORI  15 XORI 16 SLLI 17 SRLI 18 SRAI 19 SLTI 20 SLTIU
//  21 BEQ  22 BNE  23 BLT  24 BGE  25 BLTU 26 BGEU 27 MUL  28 MULH 29 MULHSU 30 MULHU

module alu_pipe #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int MUL_STAGES = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [XLEN-1:0]  in_vi,
  input  logic [XLEN-1:0]  in_vj,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_full_len,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + MUL_STAGES) + 1;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_ADD   = 6'd2;
  localparam logic [5:0] OP_SUB   = 6'd3;
  localparam logic [5:0] OP_AND   = 6'd4;
  localparam logic [5:0] OP_OR    = 6'd5;
  localparam logic [5:0] OP_XOR   = 6'd6;
  localparam logic [5:0] OP_SLL   = 6'd7;
  localparam logic [5:0] OP_SRL   = 6'd8;
  localparam logic [5:0] OP_SRA   = 6'd9;
  localparam logic [5:0] OP_SLT   = 6'd10;
  localparam logic [5:0] OP_SLTU  = 6'd11;
  localparam logic [5:0] OP_ADDI  = 6'd12;
  localparam logic [5:0] OP_ANDI  = 6'd13;
  localparam logic [5:0] OP_ORI   = 6'd14;
  localparam logic [5:0] OP_XORI  = 6'd15;
  localparam logic [5:0] OP_SLLI  = 6'd16;
  localparam logic [5:0] OP_SRLI  = 6'd17;
  localparam logic [5:0] OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_SLTI  = 6'd19;
  localparam logic [5:0] OP_SLTIU = 6'd20;
  localparam logic [5:0] OP_BEQ   = 6'd21;
  localparam logic [5:0] OP_BNE   = 6'd22;
  localparam logic [5:0] OP_BLT   = 6'd23;
  localparam logic [5:0] OP_BGE   = 6'd24;
  localparam logic [5:0] OP_BLTU  = 6'd25;
  localparam logic [5:0] OP_BGEU  = 6'd26;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [5:0] OP_MUL    = 6'd27;
  localparam logic [5:0] OP_MULH   = 6'd28;
  localparam logic [5:0] OP_MULHSU = 6'd29;
  localparam logic [5:0] OP_MULHU  = 6'd30;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic             taken;
    logic [TAG_W-1:0] tag;
  } res_t;

  // ---------------- operand preparation and combinational ALU ----------------
  logic [XLEN-1:0] imm_sext, br_target, pc_next, alu_res;
  logic [SH_W-1:0] shamt_r, shamt_i;
  logic            alu_taken, br_eq, br_lt, br_ltu;

  assign imm_sext  = {{(XLEN-12){in_imm[11]}}, in_imm[11:0]};
  assign shamt_r   = in_vj[SH_W-1:0];
  assign shamt_i   = in_imm[SH_W-1:0];
  assign br_eq     = (in_vi == in_vj);
  assign br_lt     = ($signed(in_vi) < $signed(in_vj));
  assign br_ltu    = (in_vi < in_vj);
  assign br_target = in_pc + imm_sext;
  assign pc_next   = in_pc + (in_full_len ? XLEN'(4) : XLEN'(2));

`ifdef ALU_PIPE_MUL_EN
  // One shared multiplier; each operand is sign- or zero-extended per opcode,
  // and the low 2*XLEN bits of the product are exact for every signedness mix.
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  assign mul_sa = (in_op == OP_MULH) || (in_op == OP_MULHSU);
  assign mul_sb = (in_op == OP_MULH);
  assign mul_a  = {{XLEN{mul_sa & in_vi[XLEN-1]}}, in_vi};
  assign mul_b  = {{XLEN{mul_sb & in_vj[XLEN-1]}}, in_vj};
  assign mul_p  = mul_a * mul_b;
`endif

  always_comb begin
    alu_res   = '0;
    alu_taken = 1'b0;
    case (in_op)
      OP_LUI:   alu_res = in_imm;
      OP_ADD:   alu_res = in_vi + in_vj;
      OP_SUB:   alu_res = in_vi - in_vj;
      OP_AND:   alu_res = in_vi & in_vj;
      OP_OR:    alu_res = in_vi | in_vj;
      OP_XOR:   alu_res = in_vi ^ in_vj;
      OP_SLL:   alu_res = in_vi << shamt_r;
      OP_SRL:   alu_res = in_vi >> shamt_r;
      OP_SRA:   alu_res = $unsigned($signed(in_vi) >>> shamt_r);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, br_lt};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, br_ltu};
      OP_ADDI:  alu_res = in_vi + imm_sext;
      OP_ANDI:  alu_res = in_vi & imm_sext;
      OP_ORI:   alu_res = in_vi | imm_sext;
      OP_XORI:  alu_res = in_vi ^ imm_sext;
      OP_SLLI:  alu_res = in_vi << shamt_i;
      OP_SRLI:  alu_res = in_vi >> shamt_i;
      OP_SRAI:  alu_res = $unsigned($signed(in_vi) >>> shamt_i);
      OP_SLTI:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_vi) < $signed(imm_sext))};
      OP_SLTIU: alu_res = {{(XLEN-1){1'b0}}, (in_vi < imm_sext)};
      OP_BEQ:   alu_taken = br_eq;
      OP_BNE:   alu_taken = !br_eq;
      OP_BLT:   alu_taken = br_lt;
      OP_BGE:   alu_taken = !br_lt;
      OP_BLTU:  alu_taken = br_ltu;
      OP_BGEU:  alu_taken = !br_ltu;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:    alu_res = mul_p[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_res = mul_p[2*XLEN-1:XLEN];
`endif
      default:  alu_res = '0;
    endcase
    if (in_op >= OP_BEQ && in_op <= OP_BGEU) begin
      alu_res = alu_taken ? br_target : pc_next;
    end
  end

  // ---------------- issue credit ----------------
  logic [CNT_W-1:0] count_q, count_d, inflight;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             acc, is_mul, order_ok, push, pop, mul_push;
  res_t             push_dat, mul_dat;

  assign acc = in_valid & in_ready;

`ifdef ALU_PIPE_MUL_EN
  localparam int MS = MUL_STAGES - 1;  // last register feeds the FIFO write

  logic [MS-1:0] mv_q;
  res_t          md_q [MS];

  assign is_mul   = (in_op >= OP_MUL) && (in_op <= OP_MULHU);
  // A single-cycle op would overtake an in-flight MUL, so hold it off.
  assign order_ok = is_mul || (inflight == '0);
  assign mul_push = mv_q[MS-1] & rdy_in & ~flush_in;
  assign mul_dat  = md_q[MS-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MS; i++) begin
      inflight = inflight + CNT_W'(mv_q[i]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mv_q <= '0;
      for (int i = 0; i < MS; i++) md_q[i] <= '0;
    end else if (flush_in) begin
      mv_q <= '0;
    end else if (rdy_in) begin
      mv_q[0] <= acc & is_mul;
      md_q[0] <= '{res: alu_res, taken: 1'b0, tag: in_tag};
      for (int i = 1; i < MS; i++) begin
        mv_q[i] <= mv_q[i-1];
        md_q[i] <= md_q[i-1];
      end
    end
  end
`else
  assign is_mul   = 1'b0;
  assign order_ok = 1'b1;
  assign inflight = '0;
  assign mul_push = 1'b0;
  assign mul_dat  = '0;
`endif

  assign in_ready = rst_in & rdy_in & ~flush_in & order_ok &
                    ((count_q + inflight) < CNT_W'(FIFO_DEPTH));

  // ---------------- result FIFO ----------------
  res_t mem_q [FIFO_DEPTH];

  // At most one push source is active: non-MUL accepts require an empty MUL pipe.
  always_comb begin
    push     = 1'b0;
    push_dat = '0;
    if (acc && (in_op != OP_NOP) && !is_mul) begin
      push     = 1'b1;
      push_dat = '{res: alu_res, taken: alu_taken, tag: in_tag};
    end else if (mul_push) begin
      push     = 1'b1;
      push_dat = mul_dat;
    end
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready & rdy_in & ~flush_in;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_in) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push && !flush_in) mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign out_res   = mem_q[rd_ptr_q].res;
  assign out_taken = mem_q[rd_ptr_q].taken;
  assign out_tag   = mem_q[rd_ptr_q].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Purpose : scoreboard bench for alu_pipe; directed vectors with hand-computed results.
// Latency : expected results queued at accept, popped by an independent monitor on negedge.
// Backpr. : exercises out_ready, rdy_in pause, flush and reset while results are buffered.

module tb_alu_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  localparam logic [5:0] NOP = 6'd0,  LUI = 6'd1,  ADD = 6'd2,  SUB = 6'd3,  ANDR = 6'd4;
  localparam logic [5:0] ORR = 6'd5,  XORR = 6'd6, SLL = 6'd7,  SRL = 6'd8,  SRA = 6'd9;
  localparam logic [5:0] SLT = 6'd10, SLTU = 6'd11, ADDI = 6'd12, ANDI = 6'd13, ORI = 6'd14;
  localparam logic [5:0] XORI = 6'd15, SLLI = 6'd16, SRLI = 6'd17, SRAI = 6'd18, SLTI = 6'd19;
  localparam logic [5:0] SLTIU = 6'd20, BEQ = 6'd21, BNE = 6'd22, BLT = 6'd23, BGE = 6'd24;
  localparam logic [5:0] BLTU = 6'd25, BGEU = 6'd26, MUL = 6'd27, UNK = 6'd63;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic             taken;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rdy_in = 1'b1;
  logic             flush_in = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       in_op = '0;
  logic [XLEN-1:0]  in_vi = '0, in_vj = '0, in_imm = '0, in_pc = '0;
  logic             in_full_len = 1'b1;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_res;
  logic             out_taken;
  logic [TAG_W-1:0] out_tag;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .FIFO_DEPTH(2), .MUL_STAGES(3)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_vi(in_vi),
    .in_vj(in_vj), .in_imm(in_imm), .in_pc(in_pc), .in_full_len(in_full_len),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_taken(out_taken), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next posedge whenever these hold at negedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && rdy_in && !flush_in) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_tag), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res", 64'(out_res), 64'(e.res));
        check("taken", 64'(out_taken), 64'(e.taken));
        check("tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [XLEN-1:0] vi, input logic [XLEN-1:0] vj,
                       input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc, input logic full,
                       input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] eres, input logic etaken);
    bit ok = 0;
    in_valid = 1'b1; in_op = op; in_vi = vi; in_vj = vj; in_imm = imm;
    in_pc = pc; in_full_len = full; in_tag = tag;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        if (op != NOP) sb.push_back('{res: eres, taken: etaken, tag: tag});
        break;
      end
    end
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk);
    #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_out_taken", 64'(out_taken), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: out_valid rises the cycle after accept
    out_ready = 1'b0;
    check("lat_pre", 64'(out_valid), 64'd0);
    issue(ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b1, 4'd1, 32'd1, 1'b0);
    check("lat_post", 64'(out_valid), 64'd1);
    out_ready = 1'b1;

    // Directed ALU vectors
    issue(SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b1, 4'd2, 32'hF800_0000, 1'b0);
    issue(SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 4'd3, 32'd1, 1'b0);
    issue(SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 4'd4, 32'd0, 1'b0);
    issue(SUB,  32'd0, 32'd1, 32'd0, 32'd0, 1'b1, 4'd5, 32'hFFFF_FFFF, 1'b0);
    issue(XORI, 32'h0000_F0F0, 32'd0, 32'h0000_0FFF, 32'd0, 1'b1, 4'd6, 32'hFFFF_0F0F, 1'b0);
    issue(ANDI, 32'h0000_00FF, 32'd0, 32'h0000_080F, 32'd0, 1'b1, 4'd7, 32'h0000_000F, 1'b0);
    issue(LUI,  32'd0, 32'd0, 32'h1234_5000, 32'd0, 1'b1, 4'd8, 32'h1234_5000, 1'b0);
    issue(SLL,  32'd1, 32'h21, 32'd0, 32'd0, 1'b1, 4'd9, 32'd2, 1'b0);
    issue(SRL,  32'h8000_0000, 32'd31, 32'd0, 32'd0, 1'b1, 4'd10, 32'd1, 1'b0);
    issue(SRA,  32'h8000_0000, 32'd31, 32'd0, 32'd0, 1'b1, 4'd11, 32'hFFFF_FFFF, 1'b0);
    issue(SLLI, 32'd1, 32'd0, 32'd31, 32'd0, 1'b1, 4'd12, 32'h8000_0000, 1'b0);
    issue(SLTIU, 32'd5, 32'd0, 32'h0000_0FFF, 32'd0, 1'b1, 4'd13, 32'd1, 1'b0);
    issue(SLTI, 32'd5, 32'd0, 32'h0000_0FFF, 32'd0, 1'b1, 4'd14, 32'd0, 1'b0);
    issue(NOP,  32'd1, 32'd1, 32'd0, 32'd0, 1'b1, 4'd15, 32'd0, 1'b0);
    issue(UNK,  32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0, 1'b0);

    // Branches
    issue(BNE,  32'd1, 32'd2, 32'h0000_0FF8, 32'h100, 1'b1, 4'd1, 32'h0000_00F8, 1'b1);
    issue(BEQ,  32'd1, 32'd2, 32'h0000_0FF8, 32'h100, 1'b0, 4'd2, 32'h0000_0102, 1'b0);
    issue(BLT,  32'hFFFF_FFFF, 32'd1, 32'd16, 32'h200, 1'b1, 4'd3, 32'h0000_0210, 1'b1);
    issue(BGE,  32'd1, 32'hFFFF_FFFF, 32'd8, 32'h300, 1'b1, 4'd4, 32'h0000_0308, 1'b1);
    issue(BLTU, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h400, 1'b1, 4'd5, 32'h0000_0404, 1'b0);
    issue(BGEU, 32'd1, 32'd2, 32'd8, 32'h500, 1'b1, 4'd6, 32'h0000_0504, 1'b0);
    drain("drain_alu");

    // Backpressure: two fit, third refused until a pop frees a slot
    out_ready = 1'b0;
    issue(ADD, 32'd10, 32'd1, 32'd0, 32'd0, 1'b1, 4'd1, 32'd11, 1'b0);
    issue(ADD, 32'd20, 32'd2, 32'd0, 32'd0, 1'b1, 4'd2, 32'd22, 1'b0);
    in_valid = 1'b1; in_op = ADD; in_vi = 32'd30; in_vj = 32'd3; in_tag = 4'd3;
    @(negedge clk);
    check("bp_in_ready_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_in_ready_full2", 64'(in_ready), 64'd0);
    check("bp_head_tag", 64'(out_tag), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(ADD, 32'd30, 32'd3, 32'd0, 32'd0, 1'b1, 4'd3, 32'd33, 1'b0);
    drain("drain_bp");

    // rdy_in pause: head held, nothing popped, nothing accepted
    out_ready = 1'b0;
    issue(XORR, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 32'd0, 1'b1, 4'd9, 32'hA5A5_5A5A, 1'b0);
    rdy_in = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_op = ADD; in_tag = 4'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("pause_valid", 64'(out_valid), 64'd1);
      check("pause_res", 64'(out_res), 64'hA5A5_5A5A);
      check("pause_tag", 64'(out_tag), 64'd9);
      check("pause_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rdy_in = 1'b1;
    drain("drain_pause");

    // Flush with 2 buffered and a same-cycle issue
    out_ready = 1'b0;
    issue(ORR, 32'hF0, 32'h0F, 32'd0, 32'd0, 1'b1, 4'd1, 32'hFF, 1'b0);
    issue(ORR, 32'h100, 32'h1, 32'd0, 32'd0, 1'b1, 4'd2, 32'h101, 1'b0);
    flush_in = 1'b1; in_valid = 1'b1; in_op = ADD; in_vi = 32'd5; in_vj = 32'd5; in_tag = 4'd3;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush_in = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("flush_no_late_push", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    issue(ADD, 32'd7, 32'd8, 32'd0, 32'd0, 1'b1, 4'd4, 32'd15, 1'b0);
    drain("drain_flush");

`ifdef ALU_PIPE_MUL_EN
    // MUL latency and ordering against a younger ADD
    issue(MUL, 32'd7, 32'd6, 32'd0, 32'd0, 1'b1, 4'd1, 32'd42, 1'b0);
    check("mul_lat1", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_op = ADD; in_vi = 32'd1; in_vj = 32'd1; in_tag = 4'd2;
    @(negedge clk);
    check("mul_add_stall1", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("mul_lat2", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("mul_add_stall2", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("mul_lat3", 64'(out_valid), 64'd1);
    check("mul_lat3_res", 64'(out_res), 64'd42);
    issue(ADD, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1, 4'd2, 32'd2, 1'b0);
    drain("drain_mul");
`else
    // Without the multiplier a MUL opcode is an unknown op: result 0, latency 1
    out_ready = 1'b0;
    issue(MUL, 32'd7, 32'd6, 32'd0, 32'd0, 1'b1, 4'd1, 32'd0, 1'b0);
    check("mul_dis_lat", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drain("drain_mul_dis");
`endif

    // Reset mid-traffic with 2 buffered
    out_ready = 1'b0;
    issue(ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 4'd5, 32'd3, 1'b0);
    issue(ADD, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 4'd6, 32'd7, 1'b0);
    #1;
    check("mid_full_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'd1);
    check("mid_rel_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    issue(ANDR, 32'hFF00, 32'h0FF0, 32'd0, 32'd0, 1'b1, 4'd8, 32'h0F00, 1'b0);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
